// File: rtl/counter_pkg.sv
// ============================================================================
// Module : counter_pkg
// Brief  : JK excitation codes and the Q->Q+ excitation helper shared by the
//          JK up/down counter and its storage cells.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package counter_pkg;

    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_CLR  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TGL  = 2'b11;

    // Fixed excitation choice: set on 0->1, clear on 1->0, otherwise hold.
    function automatic logic [1:0] excite(input logic q, input logic qn);
        return {~q & qn, q & ~qn};
    endfunction

endpackage

`default_nettype wire

// File: rtl/jk_cell.sv
// ============================================================================
// Module : jk_cell
// Brief  : Single JK storage bit, rising-edge, asynchronous active-low reset.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module jk_cell
    import counter_pkg::*;
(
    input  logic CLK,
    input  logic rst_n,
    input  logic j_i,
    input  logic k_i,
    output logic q_o
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = q_q;
        case ({j_i, k_i})
            JK_HOLD: q_d = q_q;
            JK_CLR:  q_d = 1'b0;
            JK_SET:  q_d = 1'b1;
            JK_TGL:  q_d = ~q_q;
            default: q_d = q_q;
        endcase
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

`default_nettype wire

// File: rtl/jk_updown_counter.sv
// ============================================================================
// Module : jk_updown_counter
// Brief  : Programmable mod-N up/down counter built from JK cells; the next
//          count is mapped back onto J/K excitation before clocking the cells.
//          Optional macro COUNT_SAT_EN selects saturation instead of wrap.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module jk_updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH   = 3,
    parameter int MODULUS = 8
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] J_vec,
    output logic [WIDTH-1:0] K_vec,
    output logic             tc
);

    generate
        if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
            $error("jk_updown_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
        end
    endgenerate

    localparam logic [WIDTH-1:0] C_MAX     = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   C_MOD_EXT = (WIDTH + 1)'(MODULUS);

`ifdef COUNT_SAT_EN
    localparam logic [WIDTH-1:0] C_UP_BOUND = C_MAX;
    localparam logic [WIDTH-1:0] C_DN_BOUND = '0;
`else
    localparam logic [WIDTH-1:0] C_UP_BOUND = '0;
    localparam logic [WIDTH-1:0] C_DN_BOUND = C_MAX;
`endif

    logic [WIDTH-1:0] cnt_d;

    // Priority load > en > hold; tc only flags a boundary the count will cross.
    always_comb begin
        cnt_d = Q;
        tc    = 1'b0;
        if (load) begin
            cnt_d = ({1'b0, load_val} < C_MOD_EXT) ? load_val : C_MAX;
        end else if (en) begin
            if (up) begin
                tc    = (Q == C_MAX);
                cnt_d = tc ? C_UP_BOUND : Q + WIDTH'(1);
            end else begin
                tc    = (Q == '0);
                cnt_d = tc ? C_DN_BOUND : Q - WIDTH'(1);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign {J_vec[gi], K_vec[gi]} = excite(Q[gi], cnt_d[gi]);

            jk_cell u_cell (
                .CLK   (CLK),
                .rst_n (rst_n),
                .j_i   (J_vec[gi]),
                .k_i   (K_vec[gi]),
                .q_o   (Q[gi])
            );
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_jk_updown_counter.sv
// ============================================================================
// Module : tb_jk_updown_counter
// Brief  : Directed self-checking bench; a mod-8 and a mod-6 instance.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_jk_updown_counter;

    logic       CLK;
    logic       rst_n;

    logic       en8, up8, ld8;
    logic [2:0] lv8, q8, j8, k8;
    logic       tc8;

    logic       en6, up6, ld6;
    logic [2:0] lv6, q6, j6, k6;
    logic       tc6;

    int checks = 0;
    int errors = 0;

`ifdef COUNT_SAT_EN
    int e1 [0:9] = '{1, 2, 3, 4, 5, 6, 7, 7, 7, 7};
    int e2 [0:7] = '{0, 0, 0, 0, 0, 0, 0, 0};
    int jk7_j = 0;
    int jk7_k = 0;
`else
    int e1 [0:9] = '{1, 2, 3, 4, 5, 6, 7, 0, 1, 2};
    int e2 [0:7] = '{5, 4, 3, 2, 1, 0, 5, 4};
    int jk7_j = 0;
    int jk7_k = 7;
`endif

    jk_updown_counter #(.WIDTH(3), .MODULUS(8)) u8 (
        .CLK(CLK), .rst_n(rst_n), .en(en8), .up(up8), .load(ld8), .load_val(lv8),
        .Q(q8), .J_vec(j8), .K_vec(k8), .tc(tc8)
    );

    jk_updown_counter #(.WIDTH(3), .MODULUS(6)) u6 (
        .CLK(CLK), .rst_n(rst_n), .en(en6), .up(up6), .load(ld6), .load_val(lv6),
        .Q(q6), .J_vec(j6), .K_vec(k6), .tc(tc6)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Inputs and checks happen 2 time units after the rising edge.
    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    initial begin
        rst_n = 1'b0;
        en8 = 1'b1; up8 = 1'b1; ld8 = 1'b0; lv8 = 3'd0;
        en6 = 1'b0; up6 = 1'b0; ld6 = 1'b0; lv6 = 3'd0;
        #3;
        chk("rst_q8", q8, 0);
        chk("rst_q6", q6, 0);
        chk("rst_tc8", tc8, 0);
        chk("rst_j8", j8, 3'b001);
        chk("rst_k8", k8, 3'b000);
        @(negedge CLK);
        rst_n = 1'b1;

        // Mod-8 count up, 10 edges
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                chk("up_j_3to4", j8, 3'b100);
                chk("up_k_3to4", k8, 3'b011);
            end
            if (i == 7) begin
                chk("up_j_at7", j8, jk7_j);
                chk("up_k_at7", k8, jk7_k);
            end
            step();
            chk("up_q", q8, e1[i]);
            chk("up_tc", tc8, (e1[i] == 7) ? 1 : 0);
        end

        // Mod-6 count down from reset, 8 edges
        en8 = 1'b0;
        en6 = 1'b1; up6 = 1'b0;
        #1;
        chk("dn_tc_at0", tc6, 1);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("dn_q", q6, e2[i]);
            chk("dn_tc", tc6, (e2[i] == 0) ? 1 : 0);
        end
        en6 = 1'b0;

        // Load beats enable; then clamp on mod-6
        ld8 = 1'b1; lv8 = 3'd4; en8 = 1'b1; up8 = 1'b1;
        #1;
        chk("ld_tc", tc8, 0);
        step();
        chk("ld_q", q8, 4);
        ld8 = 1'b0;
        ld6 = 1'b1; lv6 = 3'd7;
        step();
        chk("clamp_q6", q6, 5);
        chk("cnt_q8_5", q8, 5);
        ld6 = 1'b0;

        // Asynchronous reset between edges
        en8 = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_q", q8, 0);
        #1 rst_n = 1'b1;
        en8 = 1'b1; up8 = 1'b1;
        step();
        chk("post_rst_q", q8, 1);

        // Hold at 3 with enable low
        ld8 = 1'b1; lv8 = 3'd3;
        step();
        ld8 = 1'b0; en8 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            up8 = i[0];
            lv8 = 3'(i + 5);
            step();
            chk("hold_q", q8, 3);
            chk("hold_j", j8, 0);
            chk("hold_k", k8, 0);
            chk("hold_tc", tc8, 0);
        end

        // Direction change takes effect on the next edge
        en8 = 1'b1; up8 = 1'b1;
        step();
        chk("dir_up_q", q8, 4);
        up8 = 1'b0;
        step();
        chk("dir_dn_q", q8, 3);

`ifdef COUNT_SAT_EN
        en8 = 1'b0;
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        en8 = 1'b1; up8 = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            chk("sat_up_q", q8, (i < 7) ? i : 7);
        end
        chk("sat_up_tc", tc8, 1);
        chk("sat_up_j", j8, 0);
        chk("sat_up_k", k8, 0);
        up8 = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step();
            chk("sat_dn_q", q8, (i < 7) ? (7 - i) : 0);
        end
        chk("sat_dn_tc", tc8, 1);
        chk("sat_dn_j", j8, 0);
        chk("sat_dn_k", k8, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/jk_updown_counter.md
Name: jk_updown_counter

Overview:
- Programmable mod-N up/down counter built from a bank of JK storage cells.
- A JK cell maps (J,K,Q) to the next Q. This block works the other way: it maps the desired next count (Q to Q+) back onto J/K excitation, then clocks the cells.
- Used as the general counter in the sequential lab designs.
- Supersedes hand-wired mod-8 chains.

Parameters:
- WIDTH, 3, counter width in bits.
- MODULUS, 8, count range 0..MODULUS-1. Legal range is 2 <= MODULUS <= 2^WIDTH; elaboration errors outside it.

Ports:
- CLK  input  1  clock, rising-edge.
- rst_n  input  1  reset, asynchronous, active-low.
- en  input  1  count enable.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  value to load.
- Q  output  WIDTH  current count (the JK cell outputs).
- J_vec  output  WIDTH  current excitation J per bit (combinational).
- K_vec  output  WIDTH  current excitation K per bit (combinational).
- tc  output  1  terminal count (combinational).

Behaviour:
- Reset: rst_n low forces Q=0 immediately, regardless of CLK. J_vec/K_vec/tc follow from Q=0 and the inputs.
- Next-state selection per rising edge, priority load > en > hold:
  - load=1: Qn = load_val if load_val < MODULUS, else MODULUS-1 (clamp).
  - load=0, en=1, up=1: Qn = (Q==MODULUS-1) ? 0 : Q+1.
  - load=0, en=1, up=0: Qn = (Q==0) ? MODULUS-1 : Q-1.
  - otherwise: Qn = Q.
- Excitation encoding, per bit i, fixed rule (no don't-care freedom; keeps J_vec/K_vec deterministic):
  - J[i] = ~Q[i] & Qn[i]
  - K[i] = Q[i] & ~Qn[i]
  - Hold maps to J=K=0. J=K=1 is never generated.
- Cell update per bit: 00 hold, 01 clear, 10 set, 11 toggle. The toggle case is unreachable but is still implemented.
- Latency: one clock from input change to the Q update. No pipelining.
- tc = en & ~load & (up ? Q==MODULUS-1 : Q==0). High during the cycle before a wrap.
- Simultaneous load and en: load wins; tc is 0.
- Reset mid-count: Q clears asynchronously. The first edge after reset release counts from 0.
- Direction change mid-count is allowed. It takes effect on the next edge with no extra cycle.

Optional Feature:
- Macro COUNT_SAT_EN.
- Defined: saturating counter. Up at MODULUS-1 stays at MODULUS-1; down at 0 stays at 0. tc still asserts at the boundary. Excitation at the boundary is J=K=0.
- Undefined: wrap-around as above.

Decomposition:
- Shared package counter_pkg holds:
  - JK code constants: JK_HOLD=2'b00, JK_CLR=2'b01, JK_SET=2'b10, JK_TGL=2'b11.
  - Function excite(q, qn) returning {J,K}.
- One sub-module, jk_cell: single JK storage bit with async active-low reset, instantiated WIDTH times via generate.
- Next-state and excitation logic stay in the top module.

Test Plan:
- Reset, then en=1 up=1 load=0, MODULUS=8, 10 edges -> Q = 1,2,...,7,0,1,2. tc=1 only while Q=7. At Q=3->4: J_vec=3'b100, K_vec=3'b011.
- MODULUS=6, en=1 up=0 from reset, 8 edges -> Q = 5,4,3,2,1,0,5,4. tc=1 while Q=0 (and en=1, up=0).
- load=1 load_val=3'd4 with en=1 in the same cycle -> Q=4 next edge, tc=0 that cycle. Then MODULUS=6 with load_val=3'd7 -> Q=5 (clamp).
- Count to Q=5, drop rst_n mid-cycle between edges -> Q=0 before the next edge. Release, 1 edge up -> Q=1.
- en=0 for 5 edges at Q=3, any up/load_val -> Q stays 3, J_vec=K_vec=0, tc=0.
- COUNT_SAT_EN build, MODULUS=8, up 12 edges from 0 -> Q stays at 7 after edge 7, tc=1. Then up=0 for 10 edges -> Q stays at 0.
